// File: rtl/glitch_pkg.sv
// Shared command codes, ack codes and parser state encoding for the glitcher host interface.
package glitch_pkg;

  localparam logic [7:0] CMD_ESC     = 8'h00;
  localparam logic [7:0] CMD_SYS_RST = 8'hFF;
  localparam logic [7:0] CMD_BRD_RST = 8'hFE;
  localparam logic [7:0] CMD_ARM     = 8'hFC;
  localparam logic [7:0] CMD_DISARM  = 8'hFD;
  localparam logic [7:0] CMD_WIDTH   = 8'h10;
  localparam logic [7:0] CMD_PULSES  = 8'h11;
  localparam logic [7:0] CMD_DELAY0  = 8'h20;
  localparam logic [7:0] CMD_DELAY1  = 8'h21;
  localparam logic [7:0] CMD_DELAY2  = 8'h22;
  localparam logic [7:0] CMD_DELAY3  = 8'h23;

  localparam logic [7:0] ACK_OK  = 8'hAA;
  localparam logic [7:0] ACK_ERR = 8'hEE;

  typedef enum logic [1:0] {StIdle, StEsc, StArg, StPass} state_e;

  // Commands that take one argument byte.
  function automatic logic is_arg_cmd(input logic [7:0] b);
    return (b == CMD_WIDTH) || (b == CMD_PULSES) || (b == CMD_DELAY0) || (b == CMD_DELAY1) ||
           (b == CMD_DELAY2) || (b == CMD_DELAY3);
  endfunction

endpackage

// File: rtl/rst_stretch.sv
// Stretches a load strobe into a level held for CYCLES clocks; a new load restarts the count.
module rst_stretch #(
  parameter int unsigned CYCLES = 1200
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_level
);

  localparam int unsigned W = $clog2(CYCLES + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= W'(CYCLES);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_level = (r_cnt != '0);

endmodule

// File: rtl/glitch_cmd_ctrl.sv
// Host command parser/sequencer: decodes 0x00-escaped commands, forwards other traffic to target.
// Optional build macro CMD_ACK_EN adds a per-command ack byte stream back to the host.
module glitch_cmd_ctrl
  import glitch_pkg::*;
#(
  parameter int unsigned BOARD_RST_CYCLES = 1200,
  parameter int unsigned TIMEOUT_CYCLES   = 120000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [7:0]  o_pt_data,
  output logic        o_pt_valid,
  input  logic        i_pt_rdy,
  output logic [7:0]  o_cfg_width,
  output logic [7:0]  o_cfg_pulses,
  output logic [31:0] o_cfg_delay,
  output logic        o_glitch_arm,
  input  logic        i_glitch_done,
  output logic        o_board_rst,
  output logic        o_sys_rst_req,
  output logic        o_err_unknown,
  output logic        o_err_overflow,
  output logic [7:0]  o_ack_data,
  output logic        o_ack_valid
);

  state_e      r_state, w_state;
  logic [7:0]  r_sel, w_sel, r_remaining, w_remaining, r_pt_data, w_pt_data;
  logic [7:0]  r_width, w_width, r_pulses, w_pulses;
  logic [31:0] r_delay, w_delay, r_gap, w_gap;
  logic        r_pt_valid, w_pt_valid, r_arm, w_arm, r_sys_rst, w_sys_rst;
  logic        r_err_unk, w_err_unk, r_err_ovf, w_err_ovf;
  logic        w_brd_load, w_timeout, w_ack_fire;
  logic [7:0]  w_ack_code;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_sel       <= '0;
      r_remaining <= '0;
      r_pt_data   <= '0;
      r_pt_valid  <= 1'b0;
      r_width     <= '0;
      r_pulses    <= '0;
      r_delay     <= '0;
      r_gap       <= '0;
      r_arm       <= 1'b0;
      r_sys_rst   <= 1'b0;
      r_err_unk   <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_sel       <= w_sel;
      r_remaining <= w_remaining;
      r_pt_data   <= w_pt_data;
      r_pt_valid  <= w_pt_valid;
      r_width     <= w_width;
      r_pulses    <= w_pulses;
      r_delay     <= w_delay;
      r_gap       <= w_gap;
      r_arm       <= w_arm;
      r_sys_rst   <= w_sys_rst;
      r_err_unk   <= w_err_unk;
      r_err_ovf   <= w_err_ovf;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_sel       = r_sel;
    w_remaining = r_remaining;
    w_pt_data   = r_pt_data;
    w_pt_valid  = r_pt_valid;
    w_width     = r_width;
    w_pulses    = r_pulses;
    w_delay     = r_delay;
    w_arm       = r_arm;
    w_err_unk   = r_err_unk;
    w_err_ovf   = r_err_ovf;
    w_sys_rst   = 1'b0;
    w_brd_load  = 1'b0;
    w_ack_fire  = 1'b0;
    w_ack_code  = ACK_OK;
    w_timeout   = (r_state != StIdle) && !i_rx_valid && (r_gap >= 32'(TIMEOUT_CYCLES - 1));
    w_gap       = (i_rx_valid || (r_state == StIdle)) ? '0 : r_gap + 32'd1;

    if (r_pt_valid && i_pt_rdy) w_pt_valid = 1'b0;
    // Applied before decode so a same-cycle arm command overrides it.
    if (i_glitch_done) w_arm = 1'b0;

    if (w_timeout) begin
      w_state = StIdle;
      w_gap   = '0;
      if (r_state != StPass) begin
        w_ack_fire = 1'b1;
        w_ack_code = ACK_ERR;
      end
    end else if (i_rx_valid) begin
      unique case (r_state)
        StIdle: begin
          if (i_rx_data == CMD_ESC) begin
            w_state = StEsc;
          end else begin
            w_state     = StPass;
            w_remaining = i_rx_data;
          end
        end
        StEsc: begin
          w_state    = StIdle;
          w_ack_fire = 1'b1;
          if (i_rx_data == CMD_ESC) begin
            w_state    = StEsc;
            w_ack_fire = 1'b0;
          end else if (i_rx_data == CMD_SYS_RST) begin
            w_sys_rst = 1'b1;
            w_width   = '0;
            w_pulses  = '0;
            w_delay   = '0;
            w_arm     = 1'b0;
            w_err_unk = 1'b0;
            w_err_ovf = 1'b0;
          end else if (i_rx_data == CMD_BRD_RST) begin
            w_brd_load = 1'b1;
          end else if (i_rx_data == CMD_ARM) begin
            w_arm = 1'b1;
          end else if (i_rx_data == CMD_DISARM) begin
            w_arm = 1'b0;
          end else if (is_arg_cmd(i_rx_data)) begin
            w_sel      = i_rx_data;
            w_state    = StArg;
            w_ack_fire = 1'b0;
          end else begin
            w_err_unk  = 1'b1;
            w_ack_code = ACK_ERR;
          end
        end
        StArg: begin
          w_state    = StIdle;
          w_ack_fire = 1'b1;
          case (r_sel)
            CMD_WIDTH:  w_width        = i_rx_data;
            CMD_PULSES: w_pulses       = i_rx_data;
            CMD_DELAY0: w_delay[7:0]   = i_rx_data;
            CMD_DELAY1: w_delay[15:8]  = i_rx_data;
            CMD_DELAY2: w_delay[23:16] = i_rx_data;
            CMD_DELAY3: w_delay[31:24] = i_rx_data;
            default: ;
          endcase
        end
        StPass: begin
          if (r_pt_valid && !i_pt_rdy) begin
            w_err_ovf = 1'b1;
          end else begin
            w_pt_data  = i_rx_data;
            w_pt_valid = 1'b1;
          end
          w_remaining = r_remaining - 8'd1;
          if (r_remaining <= 8'd1) w_state = StIdle;
        end
      endcase
    end
  end

  rst_stretch #(
    .CYCLES(BOARD_RST_CYCLES)
  ) u_brd_rst (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_brd_load),
    .o_level(o_board_rst)
  );

`ifdef CMD_ACK_EN
  logic       r_ack_valid;
  logic [7:0] r_ack_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ack_valid <= 1'b0;
      r_ack_data  <= '0;
    end else begin
      r_ack_valid <= w_ack_fire;
      r_ack_data  <= w_ack_fire ? w_ack_code : 8'h00;
    end
  end

  assign o_ack_valid = r_ack_valid;
  assign o_ack_data  = r_ack_data;
`else
  logic w_ack_unused;
  assign w_ack_unused = ^{w_ack_fire, w_ack_code};
  assign o_ack_valid  = 1'b0;
  assign o_ack_data   = 8'h00;
`endif

  assign o_pt_data      = r_pt_data;
  assign o_pt_valid     = r_pt_valid;
  assign o_cfg_width    = r_width;
  assign o_cfg_pulses   = r_pulses;
  assign o_cfg_delay    = r_delay;
  assign o_glitch_arm   = r_arm;
  assign o_sys_rst_req  = r_sys_rst;
  assign o_err_unknown  = r_err_unk;
  assign o_err_overflow = r_err_ovf;

endmodule

// File: tb/tb_glitch_cmd_ctrl.sv
// Directed bench for glitch_cmd_ctrl with a passthrough scoreboard; honours CMD_ACK_EN if defined.
module tb_glitch_cmd_ctrl;

  localparam int unsigned BRC = 40;
  localparam int unsigned TO  = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  pt_data;
  logic        pt_valid;
  logic        pt_rdy = 1'b1;
  logic [7:0]  cfg_width, cfg_pulses;
  logic [31:0] cfg_delay;
  logic        glitch_arm;
  logic        glitch_done = 1'b0;
  logic        board_rst, sys_rst_req, err_unknown, err_overflow;
  logic [7:0]  ack_data;
  logic        ack_valid;
  logic [7:0]  last_ack = '0;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  glitch_cmd_ctrl #(
    .BOARD_RST_CYCLES(BRC),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_rx_data     (rx_data),
    .i_rx_valid    (rx_valid),
    .o_pt_data     (pt_data),
    .o_pt_valid    (pt_valid),
    .i_pt_rdy      (pt_rdy),
    .o_cfg_width   (cfg_width),
    .o_cfg_pulses  (cfg_pulses),
    .o_cfg_delay   (cfg_delay),
    .o_glitch_arm  (glitch_arm),
    .i_glitch_done (glitch_done),
    .o_board_rst   (board_rst),
    .o_sys_rst_req (sys_rst_req),
    .o_err_unknown (err_unknown),
    .o_err_overflow(err_overflow),
    .o_ack_data    (ack_data),
    .o_ack_valid   (ack_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every byte taken by the target must be the oldest expected one.
  always @(negedge clk) begin
    if (!rst && pt_valid && pt_rdy) begin
      if (exp_q.size() == 0) begin
        check("pt_unexpected", {24'h0, pt_data}, 32'hFFFF_FFFF);
      end else begin
        check("pt_byte", {24'h0, pt_data}, {24'h0, exp_q.pop_front()});
      end
    end
    if (ack_valid) last_ack <= ack_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    strobe(b);
    tick();
  endtask

  task automatic count_brd(input string tag);
    int n = 0;
    while (board_rst && n < 4 * BRC) begin
      n++;
      tick();
    end
    check(tag, n, BRC);
  endtask

  initial begin
    string msg = "Synchronized\r\n";
    #1;
    check("rst_pt_valid", pt_valid, 0);
    check("rst_width", cfg_width, 0);
    check("rst_delay", cfg_delay, 0);
    check("rst_arm", glitch_arm, 0);
    check("rst_board", board_rst, 0);
    check("rst_errs", {err_unknown, err_overflow, sys_rst_req}, 0);
    tick();
    rst = 1'b0;
    tick();

    // Config writes and delay byte order.
    send(8'h00); send(8'h10); send(8'h22);
    check("width", cfg_width, 32'h22);
    send(8'h00); send(8'h11); send(8'h00);
    check("pulses", cfg_pulses, 0);
    send(8'h00); send(8'h20); send(8'h32);
    check("delay0", cfg_delay, 32'h0000_0032);
    send(8'h00); send(8'h23); send(8'hA5);
    check("delay3", cfg_delay, 32'hA500_0032);

    // Unknown command, then soft reset clears config and errors.
    send(8'h00); send(8'h55);
    check("err_unknown", err_unknown, 1);
`ifdef CMD_ACK_EN
    check("ack_unknown", last_ack, 8'hEE);
`else
    check("ack_tied", {ack_valid, ack_data}, 0);
`endif
    send(8'h00); strobe(8'hFF);
    check("sys_rst_hi", sys_rst_req, 1);
    check("sysrst_width", cfg_width, 0);
    check("sysrst_delay", cfg_delay, 0);
    check("sysrst_err", err_unknown, 0);
    tick();
    check("sys_rst_lo", sys_rst_req, 0);

    // Board reset length, restart mid-pulse, repeated escape.
    send(8'h00); strobe(8'hFE);
    count_brd("brd_len");
    send(8'h00); strobe(8'hFE);
    repeat (10) tick();
    send(8'h00); strobe(8'hFE);
    count_brd("brd_restart");
    send(8'h00); send(8'h00); strobe(8'hFE);
    check("brd_esc_esc", board_rst, 1);
    count_brd("brd_esc_len");

    // Arm, then 14-byte passthrough with pt_rdy toggling.
    send(8'h00); send(8'hFC);
    check("arm", glitch_arm, 1);
    send(8'h0E);
    for (int i = 0; i < 14; i++) begin
      exp_q.push_back(msg[i]);
      pt_rdy = i[0];
      send(msg[i]);
      pt_rdy = 1'b1;
      tick();
      tick();
    end
    check("pass_q_empty", exp_q.size(), 0);
    check("pass_no_ovf", err_overflow, 0);
    check("pass_arm", glitch_arm, 1);
    send(8'h00); send(8'hFD);
    check("disarm_idle", glitch_arm, 0);

    // Stall: second byte dropped.
    pt_rdy = 1'b0;
    send(8'h02);
    exp_q.push_back(8'hAA);
    send(8'hAA);
    send(8'hBB);
    check("ovf_flag", err_overflow, 1);
    check("ovf_hold", {pt_valid, pt_data}, 9'h1AA);
    pt_rdy = 1'b1;
    tick(); tick();
    check("ovf_q_empty", exp_q.size(), 0);

    // glitch_done clears arm; same-cycle arm wins.
    send(8'h00); send(8'hFC);
    glitch_done = 1'b1;
    tick();
    glitch_done = 1'b0;
    check("done_clears", glitch_arm, 0);
    send(8'h00);
    glitch_done = 1'b1;
    strobe(8'hFC);
    glitch_done = 1'b0;
    check("arm_wins", glitch_arm, 1);

    // Timeout in ARG aborts without a write.
    send(8'h00); send(8'h10); send(8'h77);
    send(8'h00); send(8'h10);
    repeat (TO + 5) tick();
    send(8'h00); send(8'h55);
    check("timeout_width", cfg_width, 32'h77);
    check("timeout_idle", err_unknown, 1);

    // Reset in the middle of a passthrough.
    send(8'h0E);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h41 + 8'(i));
      send(8'h41 + 8'(i));
    end
    check("midpass_q", exp_q.size(), 0);
    rst = 1'b1;
    #1;
    check("midrst_outs", {pt_valid, glitch_arm, err_unknown, err_overflow, board_rst}, 0);
    check("midrst_width", cfg_width, 0);
    tick();
    rst = 1'b0;
    tick();
    send(8'h00); strobe(8'hFE);
    check("midrst_cmd", board_rst, 1);
    count_brd("midrst_brd");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
